// File: rtl/sd_block_read.sv
// rtl/sd_block_read.sv - SD SPI-mode CMD17 single-block reader
//
// Purpose: after card initialisation, issues READ_SINGLE_BLOCK (CMD17),
// checks R1, waits for the FE start token, and streams BLOCK_BYTES data
// bytes out one at a time. It then consumes the 16-bit CRC and releases the
// card with TAIL_CLKS idle clocks.
// Every flop is clocked on the falling edge of SD_CLK.
// Optional: define SD_RD_CRC_EN to check the received CRC16-CCITT
// (error code 5 on mismatch).
//
// Ports:
//   SD_CLK        in   sole clock (falling edge active)
//   rst_n         in   asynchronous active-low reset
//   init_o        in   card initialisation done
//   rd_req        in   one-cycle request pulse
//   rd_addr[31:0] in   CMD17 argument, latched on accept
//   SD_DATAOUT    in   card MISO
//   SD_CS         out  chip select, active low
//   SD_DATAIN     out  card MOSI
//   rd_busy       out  accept .. return to idle
//   rd_data[7:0]  out  received byte
//   rd_data_valid out  one-cycle strobe qualifying rd_data
//   rd_done       out  success pulse
//   rd_err        out  failure pulse
//   rd_err_code   out  failure cause, held until next accept
//                      (1 no R1, 2 bad R1, 3 no token, 4 init lost, 5 CRC)
module sd_block_read #(
  parameter int BLOCK_BYTES   = 512,
  parameter int RESP_TIMEOUT  = 80,
  parameter int TOKEN_TIMEOUT = 65535,
  parameter int TAIL_CLKS     = 8
) (
  input  logic        SD_CLK,
  input  logic        rst_n,
  input  logic        init_o,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        SD_DATAOUT,
  output logic        SD_CS,
  output logic        SD_DATAIN,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_data_valid,
  output logic        rd_done,
  output logic        rd_err,
  output logic [2:0]  rd_err_code
);

  localparam int BCW = $clog2(BLOCK_BYTES) + 1;
  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(BLOCK_BYTES - 1);
  localparam logic [15:0]    CMD_LAST   = 16'd47;
  localparam logic [15:0]    R1_LAST    = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0]    TOK_LAST   = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [15:0]    CRC_LAST   = 16'd15;
  // The done/err pulse is registered one edge early so it is visible during
  // the last tail clock; the final edge then returns to idle.
  localparam logic [15:0]    TAIL_PULSE = 16'(TAIL_CLKS - 2);
  localparam logic [15:0]    TAIL_LAST  = 16'(TAIL_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_WAIT_R1, S_WAIT_TOK, S_RX_DATA, S_RX_CRC, S_ERROR, S_TAIL
  } state_t;

  state_t           state_q;
  logic [47:0]      cmd_q;
  logic [15:0]      cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [2:0]       bit_q;
  logic [6:0]       shreg_q;     // only the 7 older bits are kept; the 8th is SD_DATAOUT
  logic             r1_on_q;     // R1 start bit has been seen
  logic             fail_q;
  logic [2:0]       err_pend_q;
  logic             cs_q, din_q, busy_q, valid_q, done_q, err_q;
  logic [7:0]       data_q;
  logic [2:0]       code_q;
`ifdef SD_RD_CRC_EN
  logic [15:0]      crc_q;
  logic [15:0]      crc_rx_q;
`endif

  assign SD_CS         = cs_q;
  assign SD_DATAIN     = din_q;
  assign rd_busy       = busy_q;
  assign rd_data       = data_q;
  assign rd_data_valid = valid_q;
  assign rd_done       = done_q;
  assign rd_err        = err_q;
  assign rd_err_code   = code_q;

  always_ff @(negedge SD_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      r1_on_q    <= 1'b0;
      fail_q     <= 1'b0;
      err_pend_q <= '0;
      cs_q       <= 1'b1;
      din_q      <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      code_q     <= '0;
`ifdef SD_RD_CRC_EN
      crc_q      <= '0;
      crc_rx_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // Losing init aborts any active phase; the tail (and its entry) still runs out.
      if (state_q != S_IDLE && state_q != S_ERROR && state_q != S_TAIL && !init_o) begin
        err_pend_q <= 3'd4;
        din_q      <= 1'b1;
        state_q    <= S_ERROR;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rd_req && init_o) begin
              cmd_q   <= {8'h51, rd_addr, 8'hFF};
              busy_q  <= 1'b1;
              code_q  <= 3'd0;
              fail_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= S_SEND_CMD;
            end
          end
          S_SEND_CMD: begin
            cs_q  <= 1'b0;
            din_q <= cmd_q[47];
            cmd_q <= {cmd_q[46:0], 1'b1};
            if (cnt_q == CMD_LAST) begin
              cnt_q   <= '0;
              r1_on_q <= 1'b0;
              state_q <= S_WAIT_R1;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_WAIT_R1: begin
            din_q <= 1'b1;
            if (!r1_on_q) begin
              if (!SD_DATAOUT) begin
                r1_on_q <= 1'b1;
                bit_q   <= 3'd1;
                shreg_q <= 7'h00;
              end else if (cnt_q == R1_LAST) begin
                err_pend_q <= 3'd1;
                state_q    <= S_ERROR;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end else begin
              shreg_q <= {shreg_q[5:0], SD_DATAOUT};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                if ({shreg_q, SD_DATAOUT} == 8'h00) begin
                  shreg_q <= 7'h7F;  // all-ones history so R1 bits cannot fake a token
                  cnt_q   <= '0;
                  state_q <= S_WAIT_TOK;
                end else begin
                  err_pend_q <= 3'd2;
                  state_q    <= S_ERROR;
                end
              end
            end
          end
          S_WAIT_TOK: begin
            shreg_q <= {shreg_q[5:0], SD_DATAOUT};
            if ({shreg_q, SD_DATAOUT} == 8'hFE) begin
              byte_cnt_q <= '0;
              bit_q      <= '0;
`ifdef SD_RD_CRC_EN
              crc_q      <= '0;
`endif
              state_q    <= S_RX_DATA;
            end else if (cnt_q == TOK_LAST) begin
              err_pend_q <= 3'd3;
              state_q    <= S_ERROR;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_RX_DATA: begin
            shreg_q <= {shreg_q[5:0], SD_DATAOUT};
            bit_q   <= bit_q + 3'd1;
`ifdef SD_RD_CRC_EN
            crc_q   <= {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ SD_DATAOUT) ? 16'h1021 : 16'h0000);
`endif
            if (bit_q == 3'd7) begin
              data_q     <= {shreg_q, SD_DATAOUT};
              valid_q    <= 1'b1;
              byte_cnt_q <= byte_cnt_q + BCW'(1);
              if (byte_cnt_q == BYTE_LAST) begin
                cnt_q   <= '0;
                state_q <= S_RX_CRC;
              end
            end
          end
          S_RX_CRC: begin
`ifdef SD_RD_CRC_EN
            crc_rx_q <= {crc_rx_q[14:0], SD_DATAOUT};
`else
            shreg_q  <= {shreg_q[5:0], SD_DATAOUT};  // CRC bits are clocked in and dropped
`endif
            if (cnt_q == CRC_LAST) begin
`ifdef SD_RD_CRC_EN
              if ({crc_rx_q[14:0], SD_DATAOUT} != crc_q) begin
                code_q <= 3'd5;
                fail_q <= 1'b1;
              end
`endif
              cs_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_TAIL;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_ERROR: begin
            code_q  <= err_pend_q;
            fail_q  <= 1'b1;
            cs_q    <= 1'b1;
            din_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_TAIL;
          end
          S_TAIL: begin
            if (cnt_q == TAIL_PULSE) begin
              if (fail_q) err_q  <= 1'b1;
              else        done_q <= 1'b1;
            end
            if (cnt_q == TAIL_LAST) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
